// File: rtl/ticket_call_dispatcher.sv
// ticket_call_dispatcher: hands the oldest waiting ticket to a free counter.
// Define CALL_RR_EN for round-robin counter choice; default is fixed priority.
module ticket_call_dispatcher #(
   parameter int NUM_W   = 6,
   parameter int MAX_NUM = 63,
   parameter int DEPTH   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ticket_issued,
   input  logic [4:0]         counter_done,
   input  logic               call_ready,
   output logic               call_valid,
   output logic [NUM_W-1:0]   call_number,
   output logic [2:0]         call_counter,
   output logic [5*NUM_W-1:0] service_number,
   output logic [4:0]         counter_busy,
   output logic [NUM_W-1:0]   waiting_count,
   output logic               overflow
);

   typedef enum logic {
      IDLE,
      ANNOUNCE
   } stateT;

   stateT            state;
   stateT            stateNext;
   logic             load;
   logic             accept;
   logic             selFound;
   logic [2:0]       selIdx;
   logic [NUM_W-1:0] head;
   logic             queueFull;

   assign accept    = (state == ANNOUNCE) && call_valid && call_ready;
   assign queueFull = (waiting_count == NUM_W'(DEPTH));

`ifdef CALL_RR_EN
   logic [2:0] rrPtr;
   logic [3:0] cand;

   // search free counters starting just after the last one assigned
   always_comb begin
      selFound = 1'b0;
      selIdx   = 3'd0;
      cand     = 4'd0;
      for (int i = 1; i <= 5; i++) begin
         cand = {1'b0, rrPtr} + 4'(i);
         if (cand >= 4'd5)
            cand = cand - 4'd5;
         if (!selFound && !counter_busy[cand[2:0]]) begin
            selFound = 1'b1;
            selIdx   = cand[2:0];
         end
      end
   end

   // remember the last assigned counter; E so that A comes first
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rrPtr <= 3'd4;
      else if (load)
         rrPtr <= selIdx;
   end
`else
   // lowest-index free counter wins
   always_comb begin
      selFound = 1'b0;
      selIdx   = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (!counter_busy[i]) begin
            selFound = 1'b1;
            selIdx   = 3'(i);
         end
      end
   end
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // next state: start a call when a ticket waits and a counter is free
   always_comb begin
      stateNext = state;
      load      = 1'b0;
      unique case (state)
         IDLE: begin
            if (waiting_count != '0 && selFound) begin
               load      = 1'b1;
               stateNext = ANNOUNCE;
            end
         end
         ANNOUNCE: begin
            if (call_ready)
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // call fields are frozen from load until acceptance
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         call_valid   <= 1'b0;
         call_number  <= '0;
         call_counter <= 3'd0;
      end else if (load) begin
         call_valid   <= 1'b1;
         call_number  <= head;
         call_counter <= selIdx;
      end else if (accept) begin
         call_valid   <= 1'b0;
      end
   end

   // next number to call; numbering skips 0 on wrap
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         head <= NUM_W'(1);
      else if (accept)
         head <= (head == NUM_W'(MAX_NUM)) ? NUM_W'(1) : head + NUM_W'(1);
   end

   // waiting count; a new ticket and an acceptance cancel out
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waiting_count <= '0;
         overflow      <= 1'b0;
      end else if (accept && !ticket_issued) begin
         waiting_count <= waiting_count - NUM_W'(1);
      end else if (!accept && ticket_issued) begin
         if (queueFull)
            overflow      <= 1'b1;
         else
            waiting_count <= waiting_count + NUM_W'(1);
      end
   end

   // per-counter busy flag and the number it serves
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter_busy   <= 5'd0;
         service_number <= '0;
      end else begin
         for (int k = 0; k < 5; k++) begin
            if (accept && call_counter == 3'(k)) begin
               counter_busy[k]                  <= 1'b1;
               service_number[k*NUM_W +: NUM_W] <= call_number;
            end else if (counter_done[k] && counter_busy[k]) begin
               counter_busy[k] <= 1'b0;
            end
         end
      end
   end

endmodule
